// File: rtl/tree_pkg.sv
// Shared definitions for the tree adder front end and the tree adder itself.
//   fill_state_e : fill buffer state of the operand packer
//   is_pow2      : elaboration-time power-of-two check
//   count_width  : width of an operand count field able to hold 0..n
package tree_pkg;

    typedef enum logic [0:0] {
        StFill,
        StFull
    } fill_state_e;

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

    function automatic int count_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/tree_vector_reg.sv
// Output register slice for a packed operand vector, with valid/ready and a count field.
// Data and count hold stable while out_valid_o is high and out_ready_i is low.
//   clk_i, rst_i              : clock, asynchronous active-high reset
//   in_valid_i / in_ready_o   : load handshake (ready when empty or draining this cycle)
//   in_data_i, in_count_i     : vector and real-operand count to load
//   out_valid_o / out_ready_i : downstream handshake
//   out_data_o, out_count_o   : registered vector and count
module tree_vector_reg #(
    parameter int unsigned N    = 8,
    parameter int unsigned P    = 8,
    parameter int unsigned CntW = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic signed [P-1:0] in_data_i [N],
    input  logic [CntW-1:0]     in_count_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic signed [P-1:0] out_data_o [N],
    output logic [CntW-1:0]     out_count_o
);

    logic                valid_q;
    logic signed [P-1:0] data_q [N];
    logic [CntW-1:0]     count_q;

    assign in_ready_o = !valid_q || out_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            count_q <= '0;
            for (int i = 0; i < int'(N); i++) begin
                data_q[i] <= '0;
            end
        end else if (in_valid_i && in_ready_o) begin
            valid_q <= 1'b1;
            data_q  <= in_data_i;
            count_q <= in_count_i;
        end else if (out_ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    assign out_count_o = count_q;

endmodule

// File: rtl/tree_operand_packer.sv
// Packs a narrow stream of signed operands (LANES per beat) into an INPUTS_AMOUNT-wide vector
// for the adder tree. A completed set double-buffers against the output register; an early
// in_last_i zero-pads the remaining slots.
//   clk_i, rst_i              : clock, asynchronous active-high reset
//   in_valid_i / in_ready_o   : input beat handshake (in_ready_o decoded from state only)
//   in_data_i [LANES]         : operands, lane k lands in slot beat*LANES+k
//   in_last_i                 : closes the vector early
//   out_valid_o / out_ready_i : packed vector handshake
//   out_data_o, out_count_o   : packed vector and number of real operands
module tree_operand_packer
    import tree_pkg::*;
#(
    parameter int unsigned INPUTS_AMOUNT = 8,
    parameter int unsigned P             = 8,
    parameter int unsigned LANES         = 1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           in_valid_i,
    output logic                           in_ready_o,
    input  logic signed [P-1:0]            in_data_i [LANES],
    input  logic                           in_last_i,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic signed [P-1:0]            out_data_o [INPUTS_AMOUNT],
    output logic [$clog2(INPUTS_AMOUNT):0] out_count_o
);

    localparam int unsigned BEATS = INPUTS_AMOUNT / LANES;
    localparam int unsigned CntW  = count_width(INPUTS_AMOUNT);
    localparam int unsigned BeatW = (BEATS > 1) ? $clog2(BEATS) : 1;

    if (!is_pow2(INPUTS_AMOUNT)) begin : g_bad_inputs
        $fatal(1, "INPUTS_AMOUNT must be a power of 2");
    end
    if (!is_pow2(LANES) || (LANES > INPUTS_AMOUNT)) begin : g_bad_lanes
        $fatal(1, "LANES must be a power of 2 not exceeding INPUTS_AMOUNT");
    end

    fill_state_e         state_q, state_d;
    logic [BeatW-1:0]    beat_q, beat_d;
    logic [CntW-1:0]     count_q, count_d;
    logic signed [P-1:0] buf_q [INPUTS_AMOUNT];
    logic signed [P-1:0] buf_d [INPUTS_AMOUNT];

    logic                reg_ready;
    logic                load_valid;
    logic signed [P-1:0] load_data [INPUTS_AMOUNT];
    logic [CntW-1:0]     load_count;

    logic                accept;
    logic                complete;
    logic [CntW-1:0]     fill_cnt;
    logic signed [P-1:0] fill_vec [INPUTS_AMOUNT];

    assign in_ready_o = (state_q == StFill);

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        count_d    = count_q;
        buf_d      = buf_q;
        load_valid = 1'b0;
        load_data  = buf_q;
        load_count = count_q;
        fill_vec   = buf_q;
        accept     = in_valid_i && (state_q == StFill);
        complete   = accept && ((beat_q == BeatW'(BEATS - 1)) || in_last_i);
        fill_cnt   = CntW'((int'(beat_q) + 1) * int'(LANES));

        unique case (state_q)
            StFill: begin
                if (accept) begin
                    for (int k = 0; k < int'(LANES); k++) begin
                        fill_vec[int'(beat_q) * int'(LANES) + k] = in_data_i[k];
                    end
                    if (complete) begin
                        // Pad above the real operands so the tree sum is unaffected.
                        for (int i = 0; i < int'(INPUTS_AMOUNT); i++) begin
                            if (CntW'(i) >= fill_cnt) begin
                                fill_vec[i] = '0;
                            end
                        end
                        beat_d = '0;
                        if (reg_ready) begin
                            load_valid = 1'b1;
                            load_data  = fill_vec;
                            load_count = fill_cnt;
                            for (int i = 0; i < int'(INPUTS_AMOUNT); i++) begin
                                buf_d[i] = '0;
                            end
                        end else begin
                            buf_d   = fill_vec;
                            count_d = fill_cnt;
                            state_d = StFull;
                        end
                    end else begin
                        buf_d  = fill_vec;
                        beat_d = beat_q + BeatW'(1);
                    end
                end
            end
            StFull: begin
                load_valid = 1'b1;
                if (reg_ready) begin
                    beat_d  = '0;
                    state_d = StFill;
                    for (int i = 0; i < int'(INPUTS_AMOUNT); i++) begin
                        buf_d[i] = '0;
                    end
                end
            end
            default: state_d = StFill;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StFill;
            beat_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(INPUTS_AMOUNT); i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            count_q <= count_d;
            buf_q   <= buf_d;
        end
    end

    tree_vector_reg #(
        .N    (INPUTS_AMOUNT),
        .P    (P),
        .CntW (CntW)
    ) u_out_reg (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (load_valid),
        .in_ready_o  (reg_ready),
        .in_data_i   (load_data),
        .in_count_i  (load_count),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_count_o (out_count_o)
    );

endmodule

// File: tb/tb_tree_operand_packer.sv
// Randomized and directed bench for tree_operand_packer with LANES = 1, 2 and 8 instances.
module tb_tree_operand_packer;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // Instance a: LANES=1, b: LANES=2, c: LANES=8
    logic va, ra, la, ova, ora;
    logic vb, rb, lb, ovb, orb;
    logic vc, rc, lc, ovc, orc;
    logic signed [7:0] da [1];
    logic signed [7:0] db [2];
    logic signed [7:0] dc [8];
    logic signed [7:0] oda [8];
    logic signed [7:0] odb [8];
    logic signed [7:0] odc [8];
    logic [3:0] oca, ocb, occ;

    tree_operand_packer #(.INPUTS_AMOUNT(8), .P(8), .LANES(1)) u_dut_a (
        .clk_i(clk), .rst_i(rst), .in_valid_i(va), .in_ready_o(ra), .in_data_i(da),
        .in_last_i(la), .out_valid_o(ova), .out_ready_i(ora), .out_data_o(oda),
        .out_count_o(oca)
    );
    tree_operand_packer #(.INPUTS_AMOUNT(8), .P(8), .LANES(2)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .in_valid_i(vb), .in_ready_o(rb), .in_data_i(db),
        .in_last_i(lb), .out_valid_o(ovb), .out_ready_i(orb), .out_data_o(odb),
        .out_count_o(ocb)
    );
    tree_operand_packer #(.INPUTS_AMOUNT(8), .P(8), .LANES(8)) u_dut_c (
        .clk_i(clk), .rst_i(rst), .in_valid_i(vc), .in_ready_o(rc), .in_data_i(dc),
        .in_last_i(lc), .out_valid_o(ovc), .out_ready_i(orc), .out_data_o(odc),
        .out_count_o(occ)
    );

    // Flattened views: element i at bits [8i +: 8]
    logic [63:0] pa_o, pb_o, pc_o, pa_i, pb_i, pc_i;
    always_comb begin
        pa_o = '0;
        pb_o = '0;
        pc_o = '0;
        pc_i = '0;
        for (int i = 0; i < 8; i++) begin
            pa_o[8*i +: 8] = oda[i];
            pb_o[8*i +: 8] = odb[i];
            pc_o[8*i +: 8] = odc[i];
            pc_i[8*i +: 8] = dc[i];
        end
        pa_i = {56'b0, da[0]};
        pb_i = {48'b0, db[1], db[0]};
    end

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [67:0] got, input logic [67:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // Reference model: operands collect in arrival order; a vector closes on last or at 8.
    logic [63:0] part [3];
    int          pcnt [3];
    logic [67:0] q0 [$];
    logic [67:0] q1 [$];
    logic [67:0] q2 [$];
    bit          hold_v [3];
    logic [67:0] hold_e [3];

    function automatic int qsize(input int id);
        case (id)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic push_exp(input int id, input logic [67:0] e);
        case (id)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic pop_exp(input int id, output logic [67:0] e, output bit ok);
        ok = (qsize(id) != 0);
        e  = '0;
        if (ok) begin
            case (id)
                0: e = q0.pop_front();
                1: e = q1.pop_front();
                default: e = q2.pop_front();
            endcase
        end
    endtask

    task automatic model_reset();
        for (int id = 0; id < 3; id++) begin
            part[id]   = '0;
            pcnt[id]   = 0;
            hold_v[id] = 1'b0;
        end
        q0.delete();
        q1.delete();
        q2.delete();
    endtask

    task automatic model_beat(input int id, input int lanes, input logic [63:0] din,
                              input logic last);
        for (int k = 0; k < lanes; k++) begin
            part[id][8*(pcnt[id]+k) +: 8] = din[8*k +: 8];
        end
        pcnt[id] += lanes;
        if (last || pcnt[id] == 8) begin
            push_exp(id, {4'(pcnt[id]), part[id]});
            part[id] = '0;
            pcnt[id] = 0;
        end
    endtask

    task automatic mon(input int id, input logic ov, input logic orr, input logic [63:0] od,
                       input logic [3:0] oc);
        logic [67:0] e;
        bit ok;
        if (hold_v[id] && ov) check_eq($sformatf("d%0d_hold", id), {oc, od}, hold_e[id]);
        if (ov && orr) begin
            pop_exp(id, e, ok);
            if (!ok) begin
                check_eq($sformatf("d%0d_unexpected_vector", id), 68'd1, 68'd0);
            end else begin
                check_eq($sformatf("d%0d_data", id), {4'b0, od}, {4'b0, e[63:0]});
                check_eq($sformatf("d%0d_count", id), {64'b0, oc}, {64'b0, e[67:64]});
            end
        end
        hold_v[id] = ov && !orr;
        hold_e[id] = {oc, od};
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (va && ra) model_beat(0, 1, pa_i, la);
            if (vb && rb) model_beat(1, 2, pb_i, lb);
            if (vc && rc) model_beat(2, 8, pc_i, lc);
            mon(0, ova, ora, pa_o, oca);
            mon(1, ovb, orb, pb_o, ocb);
            mon(2, ovc, orc, pc_o, occ);
        end else begin
            for (int id = 0; id < 3; id++) hold_v[id] = 1'b0;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] seq_vec(input int start, input int step);
        logic [63:0] v;
        for (int i = 0; i < 8; i++) v[8*i +: 8] = 8'(start + step * i);
        return v;
    endfunction

    int sum;
    int sent;
    int cycles;
    bit acc;

    initial begin
        rst = 1'b1;
        va = 0; la = 0; ora = 1; da[0] = '0;
        vb = 0; lb = 0; orb = 1; db[0] = '0; db[1] = '0;
        vc = 0; lc = 0; orc = 1;
        for (int k = 0; k < 8; k++) dc[k] = '0;
        model_reset();
        #1;
        check_eq("rst_valid", {67'b0, ova}, 68'd0);
        check_eq("rst_count", {64'b0, oca}, 68'd0);
        check_eq("rst_data", {4'b0, pa_o}, 68'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        cyc();
        check_eq("rst_ready", {67'b0, ra}, 68'd1);

        // Stream 1..8, LANES=1
        for (int i = 1; i <= 8; i++) begin
            va = 1; da[0] = 8'(i);
            check_eq("t1_ready", {67'b0, ra}, 68'd1);
            cyc();
        end
        va = 0;
        check_eq("t1_valid", {67'b0, ova}, 68'd1);
        check_eq("t1_data", {4'b0, pa_o}, {4'b0, seq_vec(1, 1)});
        check_eq("t1_count", {64'b0, oca}, 68'd8);
        cyc();
        check_eq("t1_single", {67'b0, ova}, 68'd0);

        // Early last on the first beat
        va = 1; da[0] = 8'sd42; la = 1;
        cyc();
        va = 0; la = 0;
        check_eq("t6_valid", {67'b0, ova}, 68'd1);
        check_eq("t6_data", {4'b0, pa_o}, 68'd42);
        check_eq("t6_count", {64'b0, oca}, 68'd1);
        for (int i = 0; i < 8; i++) begin
            va = 1; da[0] = 8'(100 + i);
            cyc();
        end
        va = 0;
        cyc();

        // Stall: 16 operands with out_ready low
        ora = 0;
        for (int i = 1; i <= 16; i++) begin
            va = 1; da[0] = 8'(i);
            cyc();
        end
        va = 0;
        check_eq("t3_full_ready", {67'b0, ra}, 68'd0);
        check_eq("t3_held_data", {4'b0, pa_o}, {4'b0, seq_vec(1, 1)});
        repeat (3) cyc();
        check_eq("t3_still_ready", {67'b0, ra}, 68'd0);
        check_eq("t3_still_data", {4'b0, pa_o}, {4'b0, seq_vec(1, 1)});
        ora = 1;
        cyc();
        ora = 0;
        check_eq("t3_ready_back", {67'b0, ra}, 68'd1);
        check_eq("t3_v2_valid", {67'b0, ova}, 68'd1);
        check_eq("t3_v2_data", {4'b0, pa_o}, {4'b0, seq_vec(9, 1)});
        cyc();
        ora = 1;
        cyc();
        check_eq("t3_empty", {67'b0, ova}, 68'd0);

        // Reset mid-vector, then reset in FULL
        for (int i = 0; i < 3; i++) begin
            va = 1; da[0] = 8'(20 + i);
            cyc();
        end
        va = 0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_eq("t5a_valid", {67'b0, ova}, 68'd0);
        @(negedge clk) rst = 1'b0;
        cyc();
        ora = 0;
        for (int i = 1; i <= 16; i++) begin
            va = 1; da[0] = 8'(50 + i);
            cyc();
        end
        va = 0;
        check_eq("t5_full_ready", {67'b0, ra}, 68'd0);
        check_eq("t5_first_vec", {4'b0, pa_o}, {4'b0, seq_vec(51, 1)});
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_eq("t5_rst_valid", {67'b0, ova}, 68'd0);
        check_eq("t5_rst_count", {64'b0, oca}, 68'd0);
        check_eq("t5_rst_data", {4'b0, pa_o}, 68'd0);
        @(negedge clk) rst = 1'b0;
        cyc();
        check_eq("t5_ready", {67'b0, ra}, 68'd1);
        ora = 1;
        for (int i = 0; i < 8; i++) begin
            va = 1; da[0] = 8'(8 - i);
            cyc();
        end
        va = 0;
        check_eq("t5_valid", {67'b0, ova}, 68'd1);
        check_eq("t5_data", {4'b0, pa_o}, {4'b0, seq_vec(8, -1)});
        check_eq("t5_count", {64'b0, oca}, 68'd8);
        cyc();

        // LANES=2 early last
        vb = 1; db[0] = -8'sd3; db[1] = 8'sd5; lb = 0;
        cyc();
        db[0] = 8'sd7; db[1] = -8'sd128; lb = 1;
        cyc();
        vb = 0; lb = 0;
        check_eq("t2_valid", {67'b0, ovb}, 68'd1);
        check_eq("t2_data", {4'b0, pb_o}, {4'b0, 64'h00000000_800705FD});
        check_eq("t2_count", {64'b0, ocb}, 68'd4);
        sum = 0;
        for (int i = 0; i < 8; i++) sum += int'(odb[i]);
        check_eq("t2_sum", 68'(sum), 68'(-119));
        cyc();

        // Random traffic on a and b
        for (int n = 0; n < 300; n++) begin
            va = ($urandom_range(3) != 0);
            da[0] = 8'($urandom);
            la = ($urandom_range(5) == 0);
            ora = ($urandom_range(2) != 0);
            vb = ($urandom_range(3) != 0);
            db[0] = 8'($urandom);
            db[1] = 8'($urandom);
            lb = ($urandom_range(4) == 0);
            orb = ($urandom_range(2) != 0);
            cyc();
        end
        va = 0; la = 0; ora = 1;
        vb = 0; lb = 0; orb = 1;
        repeat (12) cyc();

        // LANES=8, continuous valid, out_ready toggling
        sent = 0;
        cycles = 0;
        vc = 1;
        for (int k = 0; k < 8; k++) dc[k] = 8'($urandom);
        orc = 1;
        while (sent < 100 && cycles < 2000) begin
            acc = rc;
            cyc();
            cycles++;
            if (acc) begin
                sent++;
                for (int k = 0; k < 8; k++) dc[k] = 8'($urandom);
            end
            orc = ~orc;
        end
        vc = 0;
        orc = 1;
        check_eq("t4_sent", 68'(sent), 68'd100);
        repeat (10) cyc();

        check_eq("drain_a", 68'(qsize(0)), 68'd0);
        check_eq("drain_b", 68'(qsize(1)), 68'd0);
        check_eq("drain_c", 68'(qsize(2)), 68'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/tree_operand_packer.md
# tree_operand_packer

Streaming front end for the binary tree adder. It accepts signed P-bit operands over a narrow valid/ready stream, LANES per beat, and packs them into an INPUTS_AMOUNT-wide vector. It presents that vector on a registered valid/ready output that connects directly to the adder-tree inputs. A packed set double-buffers against the output register, so input streaming continues while downstream stalls; an early `in_last_i` zero-pads the tail, which leaves the tree sum unchanged.

## Interface
- `INPUTS_AMOUNT`, 8, vector length; must be a power of 2 (elaboration `$fatal` otherwise)
- `P`, 8, operand width (signed)
- `LANES`, 1, operands per input beat; power of 2, `LANES <= INPUTS_AMOUNT` (`$fatal` otherwise)
- `clk_i` input 1: single clock
- `rst_i` input 1: asynchronous, active-high reset
- `in_valid_i` input 1: input beat valid
- `in_ready_o` output 1: input beat accepted when `in_valid_i && in_ready_o`
- `in_data_i` input signed [P-1:0] x [LANES]: lane k is the operand at vector index `beat*LANES+k`
- `in_last_i` input 1: this beat closes the vector; remaining slots zero-filled
- `out_valid_o` output 1: packed vector valid
- `out_ready_i` input 1: downstream accepts
- `out_data_o` output signed [P-1:0] x [INPUTS_AMOUNT]: packed vector (unpacked array, adder-tree order)
- `out_count_o` output [$clog2(INPUTS_AMOUNT):0]: number of real (non-pad) operands, 1..INPUTS_AMOUNT

## Operation
- BEATS = INPUTS_AMOUNT/LANES. The beat counter `beat_q` ranges 0..BEATS-1.
- Fill buffer states:
  - FILL: `in_ready_o=1`. An accepted beat writes lanes into slots `beat_q*LANES+k`.
  - The vector completes when `beat_q==BEATS-1` or `in_last_i` is set. Completion records count `(beat_q+1)*LANES` and zeroes all slots above it.
  - FULL: the set is complete but the output register is occupied. `in_ready_o=0`.
- Transfer: a complete set moves to the output register when the register is empty or is draining this cycle (`out_valid_o && out_ready_i`).
  - Completion-beat accept with transfer possible: the set goes straight to the output register, the buffer clears, and the state stays FILL with `beat_q=0`.
  - Completion-beat accept with transfer not possible: go to FULL.
  - FULL → FILL: on the cycle the transfer happens. `beat_q` becomes 0 and the buffer clears.
- Output register: once `out_valid_o` rises, `out_data_o` and `out_count_o` are held stable until handshake.
- `in_last_i` on the final natural beat (`beat_q==BEATS-1`) is legal and equivalent to no `in_last_i`.
- `in_last_i` with `in_valid_i=0` is ignored.
- Beats are never dropped, reordered or duplicated.
- No arithmetic is performed; operands pass bit-exact.

## Timing
- Reset (asynchronous assert; release synchronous to `clk_i`):
  - state FILL, `beat_q=0`, fill buffer all zeros
  - `out_valid_o=0`, `out_data_o` all zeros, `out_count_o=0`, `in_ready_o=1` one cycle after release
- Latency: the completing beat accepted at edge n gives `out_valid_o=1` after edge n (visible in cycle n+1) if the output register was free.
- Throughput: one beat per cycle sustained, with no bubble between vectors, while `out_ready_i=1`. With LANES=INPUTS_AMOUNT that is one vector per cycle.
- `in_ready_o` is registered (depends only on state). It is not combinationally dependent on `out_ready_i`.
- Simultaneous output drain and completing beat: both happen at the same edge, and `out_valid_o` stays 1 with new data.
- Reset mid-vector or in FULL discards the partial set and any pending output; no stale data appears after reset.

## Structure
- Add a shared package `tree_pkg`:
  - function `is_pow2(int)`, used by this block and the tree adder for elaboration checks
  - localparam helper for count width `$clog2(N)+1`
- Sub-module `tree_vector_reg`: an INPUTS_AMOUNT x P register slice with valid/ready, count field, and hold-while-stalled. It is instantiated once as the output register.
- The fill buffer, beat counter and FILL/FULL FSM live in the top module.

## Test plan
- INPUTS_AMOUNT=8, LANES=1, `out_ready_i=1`; stream 1..8 → cycle after beat 8: `out_data_o={1,2,3,4,5,6,7,8}`, `out_count_o=8`, single-cycle valid; `in_ready_o` never drops.
- LANES=2; beats {−3,5},{7,−128} with `in_last_i` on beat 2 → `out_data_o={−3,5,7,−128,0,0,0,0}`, `out_count_o=4`; the downstream tree adder sum is −119.
- Hold `out_ready_i=0`; stream 16 operands (LANES=1) → first vector held stable, second vector completes into FULL, `in_ready_o=0` after beat 16. Raise `out_ready_i` for 1 cycle → vector 2 appears the next cycle and `in_ready_o=1`.
- LANES=8 (=INPUTS_AMOUNT), continuous valid, `out_ready_i` toggling 1/0 each cycle → every vector is delivered exactly once and in order; a scoreboard checks 100 random vectors.
- Assert `rst_i` asynchronously after 3 of 8 beats and while in FULL → outputs zero immediately. After release, stream 8..1 → `out_data_o={8,...,1}`, `out_count_o=8`, with no remnants of the earlier data.
- `in_last_i` on beat 1 with value 42 (LANES=1) → `{42,0,0,0,0,0,0,0}`, `out_count_o=1`; the next vector starts at slot 0.
